// File: rtl/mem_access_if.sv
// Request/response, data-memory and trace signals of the load/store engine.
// slave is the engine's view; master is the requester/memory side.
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we,
               trace_valid, trace_pc, trace_addr, trace_data
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we,
               trace_valid, trace_pc, trace_addr, trace_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store engine between the CPU memory stage and a word-wide data memory
// with combinational read. Sub-word stores are done as read-modify-write.
module mem_access_unit #(
    parameter int MEM_BYTES = 32768
) (
    input logic         clk,
    input logic         reset,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;   // sub-word stores only need the low half
    logic [31:0] pc_q;
    logic [31:0] word_q;
    logic        req_bad;

    // Extract the addressed lane of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'b00:   load_ext = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_ext = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_ext = word;
        endcase
    endfunction

    // Overlay store data onto the old word; unselected lanes pass through.
    function automatic logic [31:0] merge(input logic [31:0] word, input logic [15:0] wdata,
                                          input logic [1:0] off, input logic [1:0] size);
        logic [31:0] m;
        m = word;
        if (size == 2'b00)
            m[{off, 3'b000} +: 8] = wdata[7:0];
        else
            m[{off[1], 4'b0000} +: 16] = wdata;
        return m;
    endfunction

    assign req_bad = (bus.req_size == 2'b11)
                  || (bus.req_size == 2'b01 && bus.req_addr[0])
                  || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                  || (bus.req_addr > 32'(MEM_BYTES - 1));

    assign bus.req_ready   = (state == IDLE) && !reset;
    assign bus.trace_valid = bus.mem_we;
    assign bus.trace_pc    = pc_q;
    assign bus.trace_addr  = bus.mem_addr;
    assign bus.trace_data  = bus.mem_wdata;

    // Load result comes from the word captured in RD; zero for stores and errors.
    always_comb begin
        bus.resp_rdata = '0;
        if (state == RESP && !we_q && !bus.resp_err)
            bus.resp_rdata = load_ext(word_q, off_q, size_q, uns_q);
    end

    // Control FSM; memory and response outputs are set on the edge entering each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= '0;
            uns_q          <= 1'b0;
            off_q          <= '0;
            wdata_q        <= '0;
            pc_q           <= '0;
            word_q         <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    size_q  <= bus.req_size;
                    uns_q   <= bus.req_unsigned;
                    off_q   <= bus.req_addr[1:0];
                    wdata_q <= bus.req_wdata[15:0];
                    pc_q    <= bus.req_pc;
                    if (req_bad) begin
                        // Errors skip memory entirely.
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                    end else if (!bus.req_we || bus.req_size != 2'b10) begin
                        state        <= RD;
                        bus.mem_addr <= {bus.req_addr[31:2], 2'b00};
                    end else begin
                        state         <= WR;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        bus.mem_wdata <= bus.req_wdata;
                    end
                end
                RD: begin
                    word_q <= bus.mem_rdata;
                    if (we_q) begin
                        state         <= WR;
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= merge(bus.mem_rdata, wdata_q, off_q, size_q);
                    end else begin
                        state          <= RESP;
                        bus.mem_addr   <= '0;
                        bus.resp_valid <= 1'b1;
                    end
                end
                WR: begin
                    state          <= RESP;
                    bus.mem_we     <= 1'b0;
                    bus.mem_addr   <= '0;
                    bus.mem_wdata  <= '0;
                    bus.resp_valid <= 1'b1;
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a byte-array reference model.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset;
    logic preload;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_access_if bus();
    mem_access_unit #(.MEM_BYTES(32768)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Word-wide data memory attached to the unit.
    logic [31:0] dmem [0:8191];
    logic [7:0]  ref_mem [0:32767];

    function automatic logic [31:0] init_word(int i);
        return 32'(i) * 32'h9E3779B1 + 32'h01234567;
    endfunction

    assign bus.mem_rdata = dmem[bus.mem_addr[14:2]];

    // Memory write port, plus one-time preload of known contents.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++) dmem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            dmem[bus.mem_addr[14:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int base);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) w |= 32'(ref_mem[base + i]) << (8 * i);
        return w;
    endfunction

    // Reference: apply the access to the byte array, return the expected response.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic err, output logic [31:0] rdata,
                         output logic [31:0] wword, output int lat);
        int nb;
        logic [31:0] v;
        err   = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                (size == 2'd2 && addr % 4 != 0) || (addr >= 32'd32768);
        rdata = '0;
        wword = '0;
        nb    = 1 << size;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            v = '0;
            for (int i = 0; i < nb; i++) v |= 32'(ref_mem[int'(addr) + i]) << (8 * i);
            if (!uns && nb == 1 && v[7])  v |= 32'hFFFFFF00;
            if (!uns && nb == 2 && v[15]) v |= 32'hFFFF0000;
            rdata = v;
        end else begin
            lat = (nb == 4) ? 2 : 3;
            for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
            wword = ref_word(int'(addr) & ~3);
        end
    endtask

    // Issue one request, then check every cycle up to the one after the response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic hold,
                          output logic [31:0] got_rdata, output logic got_err, output int waited);
        logic        e_err, r_err, e_we;
        logic [31:0] e_rdata, e_word, r_rdata, pc;
        int          lat, resp_at, resp_cnt;
        pc = $urandom;
        model(we, size, uns, addr, wdata, e_err, e_rdata, e_word, lat);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_pc       = pc;
        waited = 0;
        while (!bus.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        got_rdata = '0;
        got_err   = 1'b0;
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'd1, 32'd0);
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) bus.req_valid = 1'b0;
        resp_at  = 0;
        resp_cnt = 0;
        r_rdata  = '0;
        r_err    = 1'b0;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            e_we = we && !e_err && (k == lat - 1);
            chk("mem_we", 32'(bus.mem_we), 32'(e_we));
            chk("trace_valid", 32'(bus.trace_valid), 32'(e_we));
            if (e_we) begin
                chk("wr_addr", bus.mem_addr, addr & ~32'd3);
                chk("wr_data", bus.mem_wdata, e_word);
                chk("trace_addr", bus.trace_addr, addr & ~32'd3);
                chk("trace_data", bus.trace_data, e_word);
                chk("trace_pc", bus.trace_pc, pc);
            end
            if (bus.resp_valid) begin
                resp_cnt++;
                if (resp_at == 0) begin
                    resp_at = k;
                    r_rdata = bus.resp_rdata;
                    r_err   = bus.resp_err;
                end
            end
            chk(k <= lat ? "ready_busy" : "ready_after", 32'(bus.req_ready), 32'(k > lat));
        end
        chk("resp_lat", 32'(resp_at), 32'(lat));
        chk("resp_cnt", 32'(resp_cnt), 32'd1);
        chk("resp_rdata", r_rdata, e_rdata);
        chk("resp_err", 32'(r_err), 32'(e_err));
        got_rdata = r_rdata;
        got_err   = r_err;
    endtask

    logic [31:0] rd;
    logic        er;
    int          wt;

    initial begin
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.req_pc = 0;
        for (int i = 0; i < 8192; i++)
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(init_word(i) >> (8 * b));
        reset   = 1'b1;
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_trace_pc", bus.trace_pc, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_post_rst", 32'(bus.req_ready), 32'd1);

        // Word store then load.
        do_req(1, 2'd2, 0, 32'h10, 32'h12345678, 0, rd, er, wt);
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 0, rd, er, wt);
        chk("lw_0x10", rd, 32'h12345678);
        // Byte store read-modify-write.
        do_req(1, 2'd0, 0, 32'h12, 32'hAB, 0, rd, er, wt);
        chk("sb_word", dmem[4], 32'h12AB5678);
        // Sign versus zero extension.
        do_req(1, 2'd2, 0, 32'h20, 32'h8000FF7F, 0, rd, er, wt);
        do_req(0, 2'd0, 0, 32'h21, 32'h0, 0, rd, er, wt);
        chk("lb", rd, 32'hFFFFFFFF);
        do_req(0, 2'd0, 1, 32'h21, 32'h0, 0, rd, er, wt);
        chk("lbu", rd, 32'h000000FF);
        do_req(0, 2'd1, 0, 32'h22, 32'h0, 0, rd, er, wt);
        chk("lh", rd, 32'hFFFF8000);
        do_req(0, 2'd1, 1, 32'h22, 32'h0, 0, rd, er, wt);
        chk("lhu", rd, 32'h00008000);
        // Errors.
        do_req(1, 2'd1, 0, 32'h13, 32'h5555, 0, rd, er, wt);
        chk("err_sh_odd", 32'(er), 32'd1);
        do_req(0, 2'd2, 0, 32'h22, 32'h0, 0, rd, er, wt);
        chk("err_lw_mis", 32'(er), 32'd1);
        do_req(0, 2'd3, 0, 32'h30, 32'h0, 0, rd, er, wt);
        chk("err_size3", 32'(er), 32'd1);
        do_req(0, 2'd2, 0, 32'h8000, 32'h0, 0, rd, er, wt);
        chk("err_range", 32'(er), 32'd1);
        do_req(0, 2'd2, 0, 32'h7FFC, 32'h0, 0, rd, er, wt);
        chk("last_word_ok", 32'(er), 32'd0);

        // Reset during the RD cycle of a byte store.
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'd0; bus.req_unsigned = 0;
        bus.req_addr = 32'h41; bus.req_wdata = 32'hCD;
        @(posedge clk);
        #1 bus.req_valid = 0;
        @(negedge clk);
        chk("abort_rd_addr", bus.mem_addr, 32'h40);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_resp", 32'(bus.resp_valid), 32'd0);
        chk("abort_ready_rst", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_resp2", 32'(bus.resp_valid), 32'd0);
        chk("abort_mem_we2", 32'(bus.mem_we), 32'd0);
        chk("abort_word", dmem[16], ref_word(32'h40));

        // Back-to-back loads with req_valid held.
        do_req(0, 2'd2, 0, 32'h10, 32'h0, 1, rd, er, wt);
        do_req(0, 2'd1, 1, 32'h20, 32'h0, 1, rd, er, wt);
        chk("b2b_wait", 32'(wt), 32'd0);
        do_req(0, 2'd0, 0, 32'h12, 32'h0, 0, rd, er, wt);
        chk("b2b_wait2", 32'(wt), 32'd0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 15);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'h8000 + $urandom_range(0, 15);
            else             a = $urandom_range(0, 255);
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, 1'($urandom), rd, er, wt);
        end
        bus.req_valid = 0;
        @(negedge clk);
        for (int w = 0; w < 72; w++) chk("final_mem", dmem[w], ref_word(4 * w));
        chk("final_hi_word", dmem[8191], ref_word(32'h7FFC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
